// File: rtl/alu_serial.sv
// Digit-serial ALU (ADD/INC/NEG/SUB) processing SLICE bits per clock with valid/ready on both sides.
// Optional signed-overflow flag port v_flag is built only when ALU_SERIAL_OVF_EN is defined.
module alu_serial #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             z_flag,
    output logic             n_flag,
    output logic             c_flag,
    output logic [1:0]       o_dbg_state
`ifdef ALU_SERIAL_OVF_EN
    ,
    output logic             v_flag
`endif
);

    localparam int NS = WIDTH / SLICE;
    localparam int CW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NS - 1);

    generate
        if ((WIDTH < 2) || (SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_bad_params
            $error("alu_serial: WIDTH must be >= 2 and a multiple of SLICE");
        end
    endgenerate

    // Handshake: a transfer happens on any rising edge where valid && ready are both 1;
    // the source holds its data stable until then, the sink never drops a presented item.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_step;

    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_zacc;

    logic [WIDTH-1:0] w_x_in;
    logic [WIDTH-1:0] w_y_in;
    logic             w_cin;
    logic [SLICE-1:0] w_xs;
    logic [SLICE-1:0] w_ys;
    logic [SLICE:0]   w_add;
    logic [SLICE-1:0] w_sum;
    logic             w_cout;
    logic             w_slice_zero;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Every op is folded into X + Y + cin so a single slice adder covers all four.
    always_comb begin
        w_x_in = a;
        w_y_in = b;
        w_cin  = 1'b0;
        case (op)
            2'b00: begin
                w_x_in = a;
                w_y_in = b;
                w_cin  = 1'b0;
            end
            2'b01: begin
                w_x_in = '0;
                w_y_in = b;
                w_cin  = 1'b1;
            end
            2'b10: begin
                w_x_in = ~a;
                w_y_in = '0;
                w_cin  = 1'b1;
            end
            default: begin
                w_x_in = ~a;
                w_y_in = b;
                w_cin  = 1'b1;
            end
        endcase
    end

    assign w_xs         = r_x[SLICE-1:0];
    assign w_ys         = r_y[SLICE-1:0];
    assign w_add        = {1'b0, w_xs} + {1'b0, w_ys} + {{SLICE{1'b0}}, r_carry};
    assign w_sum        = w_add[SLICE-1:0];
    assign w_cout       = w_add[SLICE];
    assign w_slice_zero = (w_sum == '0);
    assign w_last       = (r_cnt == LAST);

    // Result fills from the top: after NS shifts slice 0 sits in the LSBs.
    generate
        if (SLICE == WIDTH) begin : g_res_full
            assign w_res_next = w_sum;
        end else begin : g_res_shift
            assign w_res_next = {w_sum, result[WIDTH-1:SLICE]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_zacc  <= 1'b0;
            result  <= '0;
            z_flag  <= 1'b0;
            n_flag  <= 1'b0;
            c_flag  <= 1'b0;
        end else if (w_accept) begin
            r_x     <= w_x_in;
            r_y     <= w_y_in;
            r_carry <= w_cin;
            r_cnt   <= '0;
            r_zacc  <= 1'b1;
        end else if (w_step) begin
            r_x     <= r_x >> SLICE;
            r_y     <= r_y >> SLICE;
            r_carry <= w_cout;
            r_cnt   <= r_cnt + CW'(1);
            r_zacc  <= r_zacc & w_slice_zero;
            result  <= w_res_next;
            if (w_last) begin
                c_flag <= w_cout;
                z_flag <= r_zacc & w_slice_zero;
                n_flag <= w_sum[SLICE-1];
            end
        end
    end

`ifdef ALU_SERIAL_OVF_EN
    // Carry into the MSB recovered from the MSB sum bit: cin_msb = x ^ y ^ sum.
    logic w_cin_msb;
    assign w_cin_msb = w_xs[SLICE-1] ^ w_ys[SLICE-1] ^ w_sum[SLICE-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_flag <= 1'b0;
        end else if (w_step && w_last) begin
            v_flag <= w_cin_msb ^ w_cout;
        end
    end
`endif

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_serial.sv
// Directed + random bench for alu_serial with a queue scoreboard; also covers the SLICE==WIDTH build.
// Overflow checks become live when ALU_SERIAL_OVF_EN is defined.
module tb_alu_serial;

    localparam int WIDTH = 16;
    localparam int SLICE = 4;
    localparam int NS    = WIDTH / SLICE;
    localparam int EW    = WIDTH + 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             z_flag, n_flag, c_flag, v_obs;
    logic [1:0]       dbg_state;

    logic             d_in_valid, d_in_ready, d_out_valid, d_out_ready;
    logic [WIDTH-1:0] d_result;
    logic             d_z, d_n, d_c, d_v;
    logic [1:0]       d_dbg_state;

    int               checks = 0;
    int               errors = 0;
    logic [EW-1:0]    exp_q[$];
    logic [EW-1:0]    last_exp;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    alu_serial #(.WIDTH(WIDTH), .SLICE(SLICE)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .z_flag(z_flag), .n_flag(n_flag), .c_flag(c_flag),
        .o_dbg_state(dbg_state)
`ifdef ALU_SERIAL_OVF_EN
        , .v_flag(v_obs)
`endif
    );

    alu_serial #(.WIDTH(WIDTH), .SLICE(WIDTH)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .op(op), .a(a), .b(b), .out_valid(d_out_valid), .out_ready(d_out_ready),
        .result(d_result), .z_flag(d_z), .n_flag(d_n), .c_flag(d_c),
        .o_dbg_state(d_dbg_state)
`ifdef ALU_SERIAL_OVF_EN
        , .v_flag(d_v)
`endif
    );

`ifndef ALU_SERIAL_OVF_EN
    assign v_obs = 1'b0;
    assign d_v   = 1'b0;
`endif

    // ---------------- model / helpers ----------------
    function automatic logic [EW-1:0] model(input logic [1:0] m_op,
                                            input logic [WIDTH-1:0] m_a,
                                            input logic [WIDTH-1:0] m_b);
        logic [WIDTH-1:0] x, y;
        logic             cin, v;
        logic [WIDTH:0]   s;
        case (m_op)
            2'b00:   begin x = m_a;  y = m_b; cin = 1'b0; end
            2'b01:   begin x = '0;   y = m_b; cin = 1'b1; end
            2'b10:   begin x = ~m_a; y = '0;  cin = 1'b1; end
            default: begin x = ~m_a; y = m_b; cin = 1'b1; end
        endcase
        s = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
        v = (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
`ifndef ALU_SERIAL_OVF_EN
        v = 1'b0;
`endif
        return {v, s[WIDTH], s[WIDTH-1], (s[WIDTH-1:0] == '0), s[WIDTH-1:0]};
    endfunction

    function automatic logic [EW-1:0] obs_word();
        return {v_obs, c_flag, n_flag, z_flag, result};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input logic [1:0] s_op, input logic [WIDTH-1:0] s_a, input logic [WIDTH-1:0] s_b);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("send_ready", in_ready, 1);
        op       = s_op;
        a        = s_a;
        b        = s_b;
        in_valid = 1'b1;
        exp_q.push_back(model(s_op, s_a, s_b));
        tick();
        in_valid = 1'b0;
        op       = 2'($urandom_range(0, 3));
        a        = WIDTH'($urandom_range(0, 65535));
        b        = WIDTH'($urandom_range(0, 65535));
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, n, NS);
        check({tag, "_sb"}, exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            last_exp = exp_q.pop_front();
            check({tag, "_res"}, obs_word(), last_exp);
        end
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle_rdy"}, in_ready, 1);
        check({tag, "_idle_ov"}, out_valid, 0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] s_op,
                          input logic [WIDTH-1:0] s_a, input logic [WIDTH-1:0] s_b);
        send(s_op, s_a, s_b);
        wait_done(tag);
        release_out(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        d_in_valid  = 1'b0;
        d_out_ready = 1'b0;
        op          = 2'b00;
        a           = '0;
        b           = '0;
        last_exp    = '0;
        #3;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_word", obs_word(), 0);
        check("rst_state", dbg_state, 0);
        #9 rst_n = 1'b1;
        tick();

        // Basic ops
        run_op("add_1234", 2'b00, 16'h1234, 16'h4321);
        check("add_1234_val", last_exp, {4'b0000, 16'h5555});
        run_op("sub_5_3", 2'b11, 16'd5, 16'd3);
        run_op("sub_3_3", 2'b11, 16'd3, 16'd3);
        run_op("inc_ffff", 2'b01, 16'h0000, 16'hFFFF);
        run_op("neg_1", 2'b10, 16'h0001, 16'h0000);
        check("neg_1_res_hold", result, 16'hFFFF);
        run_op("ovf_7fff", 2'b00, 16'h7FFF, 16'h0001);
        run_op("ovf_1_1", 2'b00, 16'h0001, 16'h0001);

        // Backpressure in DONE with an ignored in_valid pulse
        send(2'b00, 16'hA5A5, 16'h0F0F);
        wait_done("bp");
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                in_valid = 1'b1;
                op       = 2'b01;
                b        = 16'h1111;
            end
            tick();
            in_valid = 1'b0;
            check("bp_stable", obs_word(), last_exp);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        release_out("bp");
        tick();
        check("bp_no_accept", dbg_state, 0);
        check("bp_hold_idle", obs_word(), last_exp);

        // Asynchronous reset during BUSY slice 2
        send(2'b00, 16'h1234, 16'h4321);
        tick();
        tick();
        check("rst_mid_busy", dbg_state, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstm_out_valid", out_valid, 0);
        check("rstm_result", result, 0);
        check("rstm_in_ready", in_ready, 1);
        check("rstm_flags", {v_obs, c_flag, n_flag, z_flag}, 0);
        exp_q.delete();
        #1 rst_n = 1'b1;
        tick();
        run_op("after_rst", 2'b11, 16'h0010, 16'h0100);

        // Random operations
        for (int i = 0; i < 10; i++) begin
            run_op("rand", 2'($urandom_range(0, 3)), WIDTH'($urandom_range(0, 65535)),
                   WIDTH'($urandom_range(0, 65535)));
        end

        // SLICE == WIDTH instance: single BUSY cycle
        begin
            int n = 0;
            op         = 2'b00;
            a          = 16'h1234;
            b          = 16'h4321;
            d_in_valid = 1'b1;
            tick();
            d_in_valid = 1'b0;
            while (!d_out_valid && n < 20) begin
                tick();
                n++;
            end
            check("s16_lat", n, 1);
            check("s16_res", {d_v, d_c, d_n, d_z, d_result}, {4'b0000, 16'h5555});
            d_out_ready = 1'b1;
            tick();
            d_out_ready = 1'b0;
            check("s16_idle", d_in_ready, 1);
            check("s16_state", d_dbg_state, 0);
        end

        check("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=no_finish expected=finish");
        $fatal(1, "timeout");
    end

endmodule
